// File: rtl/bsg_wormhole_conc_arb_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : bsg_wormhole_conc_arb_pkg                                  |
// | Brief   : Shared types for the wormhole concentrator arbiter.        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package bsg_wormhole_conc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_wormhole_conc_arb_rr.sv
// +----------------------------------------------------------------------+
// | Module  : bsg_wormhole_conc_arb_rr                                   |
// | Brief   : Rotating priority encoder; search starts at last+1.        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module bsg_wormhole_conc_arb_rr #(
  parameter int NUM_IN_P   = 4,
  parameter int ID_WIDTH_P = 2
) (
  input  logic [NUM_IN_P-1:0]   v,
  input  logic [ID_WIDTH_P-1:0] last,
  output logic [NUM_IN_P-1:0]   onehot,
  output logic [ID_WIDTH_P-1:0] id,
  output logic                  any
);

  logic [ID_WIDTH_P-1:0] w_idx;

  // Offset num_in_p wraps back onto last itself, so it is searched last.
  always_comb begin
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int k = 1; k <= NUM_IN_P; k++) begin
      w_idx = ID_WIDTH_P'((int'(last) + k) % NUM_IN_P);
      if (!any && v[w_idx]) begin
        any           = 1'b1;
        onehot[w_idx] = 1'b1;
        id            = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsg_wormhole_concentrator_arbiter.sv
// +----------------------------------------------------------------------+
// | Module  : bsg_wormhole_concentrator_arbiter                          |
// | Brief   : Round-robin wormhole arbiter; holds a grant for len flits. |
// |           BSG_WORMHOLE_CONC_ARB_STATS_EN adds a header counter.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_wormhole_concentrator_arbiter
  import bsg_wormhole_conc_arb_pkg::*;
#(
  parameter  int num_in_p    = 4,
  parameter  int len_width_p = 4,
  localparam int id_width_lp = `BSG_SAFE_CLOG2(num_in_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_in_p-1:0]                  v_i,
  input  logic [num_in_p-1:0][len_width_p-1:0] len_i,
  output logic [num_in_p-1:0]                  yumi_o,
  input  logic                                 ready_i,
  output logic                                 v_o,
  output logic [num_in_p-1:0]                  sel_one_hot_o,
  output logic [id_width_lp-1:0]               sel_id_o,
  output logic                                 busy_o
`ifdef BSG_WORMHOLE_CONC_ARB_STATS_EN
  ,
  output logic [31:0]                          pkt_count_o
`endif
);

  state_e                 r_state;
  logic [len_width_p-1:0] r_cnt;
  logic [id_width_lp-1:0] r_owner;
  logic [id_width_lp-1:0] r_last;

  logic [num_in_p-1:0]    w_rr_oh;
  logic [id_width_lp-1:0] w_rr_id;
  logic                   w_rr_any;
  logic [num_in_p-1:0]    w_owner_oh;

  logic                   w_v;
  logic [num_in_p-1:0]    w_sel_oh;
  logic [id_width_lp-1:0] w_sel_id;
  logic                   w_hdr_acc;
  logic [id_width_lp-1:0] w_hdr_id;
  logic [len_width_p-1:0] w_hdr_len;
  logic                   w_xfer;

  bsg_wormhole_conc_arb_rr #(
    .NUM_IN_P   (num_in_p),
    .ID_WIDTH_P (id_width_lp)
  ) u_rr (
    .v      (v_i),
    .last   (r_last),
    .onehot (w_rr_oh),
    .id     (w_rr_id),
    .any    (w_rr_any)
  );

  assign w_owner_oh = {{(num_in_p-1){1'b0}}, 1'b1} << r_owner;

  always_comb begin
    w_v       = 1'b0;
    w_sel_oh  = '0;
    w_sel_id  = '0;
    w_hdr_acc = 1'b0;
    w_hdr_id  = r_owner;
    w_xfer    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_v       = w_rr_any;
        w_sel_oh  = w_rr_oh;
        w_sel_id  = w_rr_id;
        w_hdr_id  = w_rr_id;
        w_hdr_acc = w_rr_any & ready_i;
      end
      // Header already offered downstream; it must stay put until taken.
      ST_HOLD: begin
        w_v       = 1'b1;
        w_sel_oh  = w_owner_oh;
        w_sel_id  = r_owner;
        w_hdr_acc = ready_i;
      end
      ST_BUSY: begin
        w_v      = v_i[r_owner];
        w_sel_oh = w_owner_oh;
        w_sel_id = r_owner;
        w_xfer   = v_i[r_owner] & ready_i;
      end
      default: begin
        w_v = 1'b0;
      end
    endcase
  end

  assign w_hdr_len = len_i[w_hdr_id];

  // Reset gates every output so nothing is dequeued while held in reset.
  assign v_o           = reset_n_i & w_v;
  assign yumi_o        = (reset_n_i && (w_hdr_acc || w_xfer)) ? w_sel_oh : '0;
  assign sel_one_hot_o = reset_n_i ? w_sel_oh : '0;
  assign sel_id_o      = reset_n_i ? w_sel_id : '0;
  assign busy_o        = reset_n_i & (r_state != ST_IDLE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_last  <= id_width_lp'(num_in_p - 1);
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_hdr_acc) begin
            r_last <= w_hdr_id;
            if (w_hdr_len != '0) begin
              r_cnt   <= w_hdr_len;
              r_owner <= w_hdr_id;
              r_state <= ST_BUSY;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if ((r_state == ST_IDLE) && w_rr_any) begin
            r_owner <= w_rr_id;
            r_state <= ST_HOLD;
          end
        end
        ST_BUSY: begin
          if (w_xfer) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == len_width_p'(1)) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BSG_WORMHOLE_CONC_ARB_STATS_EN
  logic [31:0] r_pkt_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pkt_count <= '0;
    end else if (w_hdr_acc && (r_pkt_count != 32'hFFFF_FFFF)) begin
      r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign pkt_count_o = r_pkt_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_wormhole_concentrator_arbiter.sv
// +----------------------------------------------------------------------+
// | Module  : tb_bsg_wormhole_concentrator_arbiter                       |
// | Brief   : Directed scoreboard bench for the concentrator arbiter.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bsg_wormhole_concentrator_arbiter;

  localparam int N   = 4;
  localparam int LW  = 4;
  localparam int IDW = 2;

  logic                 clk = 1'b0;
  logic                 reset_n_i;
  logic [N-1:0]         v_i;
  logic [N-1:0][LW-1:0] len_i;
  logic [N-1:0]         yumi_o;
  logic                 ready_i;
  logic                 v_o;
  logic [N-1:0]         sel_one_hot_o;
  logic [IDW-1:0]       sel_id_o;
  logic                 busy_o;
`ifdef BSG_WORMHOLE_CONC_ARB_STATS_EN
  logic [31:0]          pkt_count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  bsg_wormhole_concentrator_arbiter #(
    .num_in_p    (N),
    .len_width_p (LW)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .v_i           (v_i),
    .len_i         (len_i),
    .yumi_o        (yumi_o),
    .ready_i       (ready_i),
    .v_o           (v_o),
    .sel_one_hot_o (sel_one_hot_o),
    .sel_id_o      (sel_id_o),
    .busy_o        (busy_o)
`ifdef BSG_WORMHOLE_CONC_ARB_STATS_EN
    ,
    .pkt_count_o   (pkt_count_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Pops the next expected grant and checks the dequeue strobe against it.
  task automatic expect_grant(input string tag);
    int unsigned id;
    chk({tag, "_onehot0"}, 32'($onehot0(yumi_o)), 32'd1);
    chk({tag, "_yumi_gated"}, 32'((|yumi_o) & ~(v_o & ready_i)), 32'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_yumi"}, 32'(yumi_o), 32'd0);
    end else begin
      id = exp_q.pop_front();
      chk({tag, "_yumi"}, 32'(yumi_o), 32'd1 << id);
      chk({tag, "_sel_id"}, 32'(sel_id_o), id);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0;
    v_i       = 4'b1111;
    ready_i   = 1'b1;
    len_i     = '0;
    #2;
    chk("rst_v_o",    32'(v_o), 32'd0);
    chk("rst_yumi",   32'(yumi_o), 32'd0);
    chk("rst_sel_oh", 32'(sel_one_hot_o), 32'd0);
    chk("rst_sel_id", 32'(sel_id_o), 32'd0);
    chk("rst_busy",   32'(busy_o), 32'd0);
    tick(); settle();
    chk("rst_yumi_clk", 32'(yumi_o), 32'd0);

    // Four requesters, single-flit packets: strict rotation from input 0.
    tick(); reset_n_i = 1'b1; settle();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin tick(); settle(); end
      expect_grant("rr");
      chk("rr_v_o", 32'(v_o), 32'd1);
      chk("rr_busy", 32'(busy_o), 32'd0);
    end
    tick(); v_i = 4'b0000; settle();
    chk("idle_v_o", 32'(v_o), 32'd0);
    chk("idle_sel_oh", 32'(sel_one_hot_o), 32'd0);

    // Input 2 sends header + 3 flits; input 0 waits until the packet ends.
    tick(); v_i = 4'b0100; len_i[2] = 4'd3; settle();
    exp_q.push_back(2);
    expect_grant("pkt_hdr");
    chk("pkt_hdr_busy", 32'(busy_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); if (k == 0) v_i[0] = 1'b1; settle();
      exp_q.push_back(2);
      expect_grant("pkt_body");
      chk("pkt_body_busy", 32'(busy_o), 32'd1);
    end
    tick(); settle();
    exp_q.push_back(0);
    expect_grant("pkt_next");
    chk("pkt_next_busy", 32'(busy_o), 32'd0);

    // Owner stalls two cycles mid-packet; exactly two transfers remain.
    tick(); v_i = 4'b0010; len_i[1] = 4'd2; len_i[2] = 4'd0; settle();
    exp_q.push_back(1);
    expect_grant("stall_hdr");
    for (int k = 0; k < 2; k++) begin
      tick(); v_i = 4'b0000; settle();
      chk("stall_v_o", 32'(v_o), 32'd0);
      chk("stall_yumi", 32'(yumi_o), 32'd0);
      chk("stall_busy", 32'(busy_o), 32'd1);
    end
    for (int k = 0; k < 2; k++) begin
      tick(); v_i = 4'b0010; settle();
      exp_q.push_back(1);
      expect_grant("stall_body");
      chk("stall_body_busy", 32'(busy_o), 32'd1);
    end
    tick(); v_i = 4'b0000; settle();
    chk("stall_done_busy", 32'(busy_o), 32'd0);

    // Reset in the middle of a 5-flit packet.
    tick(); v_i = 4'b1000; len_i[3] = 4'd5; settle();
    exp_q.push_back(3);
    expect_grant("mid_hdr");
    tick(); ready_i = 1'b0; settle();
    chk("mid_busy", 32'(busy_o), 32'd1);
    chk("mid_yumi", 32'(yumi_o), 32'd0);
    ready_i = 1'b1; reset_n_i = 1'b0; settle();
    chk("mid_rst_v_o", 32'(v_o), 32'd0);
    chk("mid_rst_yumi", 32'(yumi_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_sel_oh", 32'(sel_one_hot_o), 32'd0);
    chk("mid_rst_sel_id", 32'(sel_id_o), 32'd0);
    tick(); settle();
    chk("mid_rst_yumi_clk", 32'(yumi_o), 32'd0);
    tick(); reset_n_i = 1'b1; v_i = 4'b0000; len_i = '0; settle();
    chk("mid_rel_busy", 32'(busy_o), 32'd0);

    // Downstream not ready: header is held with owner 0, no winner change.
    tick(); v_i = 4'b0011; ready_i = 1'b0; settle();
    chk("hold_v_o", 32'(v_o), 32'd1);
    chk("hold_first_id", 32'(sel_id_o), 32'd0);
    chk("hold_first_yumi", 32'(yumi_o), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick(); v_i = 4'b1011; settle();
      chk("hold_busy", 32'(busy_o), 32'd1);
      chk("hold_sel_oh", 32'(sel_one_hot_o), 32'd1);
      chk("hold_sel_id", 32'(sel_id_o), 32'd0);
      chk("hold_v_o2", 32'(v_o), 32'd1);
      chk("hold_yumi", 32'(yumi_o), 32'd0);
    end
    tick(); ready_i = 1'b1; settle();
    exp_q.push_back(0);
    expect_grant("hold_acc");
    tick(); v_i = 4'b0010; settle();
    exp_q.push_back(1);
    expect_grant("hold_next");
    tick(); v_i = 4'b0000; settle();

`ifdef BSG_WORMHOLE_CONC_ARB_STATS_EN
    reset_n_i = 1'b0; settle();
    chk("stats_rst", pkt_count_o, 32'd0);
    tick(); reset_n_i = 1'b1; settle();
    for (int k = 0; k < 10; k++) begin
      tick(); v_i = 4'b0001; settle();
      exp_q.push_back(0);
      expect_grant("stats_pkt");
    end
    tick(); v_i = 4'b0000; settle();
    chk("stats_ten", pkt_count_o, 32'd10);
    force dut.r_pkt_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_pkt_count;
    for (int k = 0; k < 2; k++) begin
      tick(); v_i = 4'b0001; settle();
      exp_q.push_back(0);
      expect_grant("stats_sat_pkt");
    end
    tick(); v_i = 4'b0000; settle();
    chk("stats_sat", pkt_count_o, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bsg_wormhole_concentrator_arbiter.md
BSG_WORMHOLE_CONCENTRATOR_ARBITER -- requirements
Module: bsg_wormhole_concentrator_arbiter

Interface
REQ-001 SHALL have parameter num_in_p, default 4; number of requesting input links, at least 2.
REQ-002 SHALL have parameter len_width_p, default 4; width of the wormhole header len field (flits after header).
REQ-003 SHALL have derived localparam id_width_lp = `BSG_SAFE_CLOG2(num_in_p).
REQ-004 SHALL have port clk_i, input, 1 bit; the single clock.
REQ-005 SHALL have port reset_n_i, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port v_i, input, [num_in_p]; head-flit valid of each input FIFO.
REQ-007 SHALL have port len_i, input, [num_in_p][len_width_p]; len field of each head flit, sampled only at header.
REQ-008 SHALL have port yumi_o, output, [num_in_p]; dequeue strobe to each input FIFO.
REQ-009 SHALL have port ready_i, input, 1 bit; concentrated output link ready.
REQ-010 SHALL have port v_o, output, 1 bit; concentrated output valid.
REQ-011 SHALL have port sel_one_hot_o, output, [num_in_p]; datapath mux select.
REQ-012 SHALL have port sel_id_o, output, [id_width_lp]; encoded owner, used as cid.
REQ-013 SHALL have port busy_o, output, 1 bit; high when not in IDLE.

Function
REQ-014 SHALL implement states IDLE, HOLD and BUSY.
REQ-015 IDLE: SHALL pick winner w by round-robin over v_i, starting at last_r+1 and wrapping modulo num_in_p; v_o = |v_i; sel = w, combinational.
REQ-016 IDLE, no v_i: SHALL drive v_o=0, sel_one_hot_o=0, sel_id_o=0.
REQ-017 IDLE with v_o & ready_i: SHALL assert yumi_o[w] and set last_r=w; if len_i[w]==0, stay IDLE; else load cnt_r=len_i[w] and owner_r=w, then go BUSY.
REQ-018 IDLE with v_o & !ready_i: SHALL latch owner_r=w and go HOLD, so no valid retraction or winner change can occur.
REQ-019 HOLD: SHALL drive sel=owner_r and v_o=1, ignoring other v_i; on ready_i, apply the REQ-017 accept rule for owner_r.
REQ-020 BUSY: SHALL drive sel=owner_r, v_o=v_i[owner_r] and yumi_o[owner_r]=v_i[owner_r]&ready_i; each transfer decrements cnt_r.
REQ-021 BUSY: a transfer with cnt_r==1 SHALL return the block to IDLE next cycle, with zero bubble before the next header.
REQ-022 At most one yumi_o bit SHALL be high in any cycle, and yumi_o SHALL never be high without v_o & ready_i.
REQ-023 Simultaneous requests SHALL be granted in rotation; no input SHALL wait more than num_in_p-1 packets.
REQ-024 Latency SHALL be 0 cycles from v_i to v_o in IDLE.

Reset
REQ-025 Reset SHALL clear state to IDLE, cnt_r=0, owner_r=0, last_r=num_in_p-1, so input 0 has first priority.
REQ-026 Outputs under reset SHALL be v_o=0, yumi_o=0, sel_one_hot_o=0, sel_id_o=0, busy_o=0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet immediately; no yumi_o SHALL occur while reset_n_i is low.

Configuration
REQ-028 Macro BSG_WORMHOLE_CONC_ARB_STATS_EN, when defined, SHALL add output pkt_count_o [32], counting accepted headers, saturating at 2^32-1 and reset to 0.
REQ-029 Without BSG_WORMHOLE_CONC_ARB_STATS_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package bsg_wormhole_conc_arb_pkg SHALL hold the state enum typedef (IDLE/HOLD/BUSY, 2 bits).
REQ-031 The rotating priority encoder SHALL be sub-module bsg_wormhole_conc_arb_rr, with inputs v and last, and outputs onehot, id and any.

Verification (num_in_p=4, len_width_p=4)
REQ-032 Reset release, v_i=4'b1111, ready_i=1, all len=0 -> grants 0,1,2,3,0 on consecutive cycles, one yumi per cycle.
REQ-033 v_i[2]=1, len=3, ready_i=1 -> 4 consecutive transfers with sel_id_o=2; a v_i[0] raised mid-packet is not granted until cycle 5.
REQ-034 v_i=4'b0011, ready_i=0 for 3 cycles -> HOLD with owner 0; raising v_i[3] does not change sel; ready_i=1 -> yumi_o=4'b0001.
REQ-035 BUSY with len=2, v_i[owner] dropped 2 cycles -> v_o=0, cnt_r unchanged; resume -> finishes after exactly 2 more transfers.
REQ-036 reset_n_i pulsed low during BUSY cnt_r=5 -> immediate IDLE, outputs zero; after release input 0 has priority.
REQ-037 With STATS_EN, 10 single-flit packets -> pkt_count_o=10; forced near-max value -> saturates at 2^32-1.
